// File: rtl/aes_pkg.sv
// Shared AES definitions for the round controller.
//   aes_ctrl_state_t : controller FSM state (IDLE, RUN, DONE)
//   ROUND_W(nr)      : width of a round counter that spans 0..nr
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_ctrl_state_t;

    function automatic int unsigned ROUND_W(input int unsigned nr);
        return $clog2(nr + 1);
    endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// Sequencing controller for an iterative AES-encrypt datapath.
// Accepts a cipher key (exp_load strobes the key-expansion block) and plaintext blocks,
// steps the round counter, muxes the round key out of the expanded key array and drives
// the datapath load/round/final strobes.
//   clk, reset            : clock, asynchronous active-high reset
//   key_valid/key_ready   : key handshake (key data goes straight to the expansion block)
//   exp_load              : load strobe to the key-expansion registers
//   rkey                  : expanded key words from the expansion block
//   in_valid/in_ready     : plaintext handshake
//   out_valid/out_ready   : ciphertext handshake
//   dp_load/round/final   : datapath strobes (round 0 load, round update, no MixColumns)
//   round, rkey_sel       : current round index and its 128-bit round key
//   key_loaded            : a key has been expanded since reset
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = Nk + 6,
    localparam int unsigned RoundW = ROUND_W(Nr),
    localparam int unsigned NumWords = 4 * (Nr + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    output logic              key_ready,
    output logic              exp_load,
    input  logic [31:0]       rkey [NumWords],
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              dp_load,
    output logic              dp_round,
    output logic              dp_final,
    output logic [RoundW-1:0] round,
    output logic [127:0]      rkey_sel,
    output logic              key_loaded
);

    localparam logic [RoundW-1:0] LastRound = RoundW'(Nr);

    aes_ctrl_state_t   state_q, state_d;
    logic [RoundW-1:0] round_q, round_d;
    logic              key_loaded_q, key_loaded_d;

    // Handshake and strobe decode. Keys are only taken in IDLE, so the expanded key
    // cannot change while a block is in flight.
    always_comb begin
        key_ready = (state_q == IDLE);
        exp_load  = key_valid & key_ready;
        // A key arriving with a block wins; the block waits one cycle.
        in_ready  = key_ready & key_loaded_q & ~key_valid;
        dp_load   = in_valid & in_ready;
        dp_round  = (state_q == RUN);
        dp_final  = dp_round & (round_q == LastRound);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        key_loaded_d = key_loaded_q | exp_load;
        unique case (state_q)
            IDLE: begin
                if (dp_load) begin
                    state_d = RUN;
                    round_d = RoundW'(1);
                end
            end
            RUN: begin
                if (round_q == LastRound) begin
                    state_d = DONE;
                end else begin
                    round_d = round_q + RoundW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    round_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            round_q      <= '0;
            key_loaded_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            key_loaded_q <= key_loaded_d;
        end
    end

    // Round-key mux; an out-of-range counter falls back to round 0.
    always_comb begin
        rkey_sel = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            rkey_sel[32*j+:32] = rkey[j];
        end
        for (int unsigned r = 1; r <= Nr; r++) begin
            if (round_q == RoundW'(r)) begin
                for (int unsigned j = 0; j < 4; j++) begin
                    rkey_sel[32*j+:32] = rkey[4*r+j];
                end
            end
        end
    end

    assign round      = round_q;
    assign key_loaded = key_loaded_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl. Two controllers (AES-128 and AES-256) sit beside a
// behavioural key-expansion register and round datapath; ciphertext is checked against a
// reference AES encryption and known FIPS-197 vectors, control outputs against a
// cycle-count model of a block's life.
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // AES-128 instance
    logic         key_valid, key_ready, exp_load, in_valid, in_ready, out_valid, out_ready;
    logic         dp_load, dp_round, dp_final, key_loaded;
    logic [3:0]   round;
    logic [127:0] rkey_sel, pt, st4;
    logic [31:0]  rk4 [44];
    logic [255:0] kd;
    logic [1919:0] ew4;

    // AES-256 instance
    logic         key_valid_b, key_ready_b, exp_load_b, in_valid_b, in_ready_b, out_valid_b;
    logic         out_ready_b, dp_load_b, dp_round_b, dp_final_b, key_loaded_b;
    logic [3:0]   round_b;
    logic [127:0] rkey_sel_b, pt_b, st8;
    logic [31:0]  rk8 [60];
    logic [255:0] kd_b;
    logic [1919:0] ew8;

    logic [7:0]   sbox_t [256];
    int           n_checks = 0;
    int           n_pass = 0;

    aes_round_ctrl #(.Nk(4)) u_dut4 (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_ready(key_ready),
        .exp_load(exp_load), .rkey(rk4), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .dp_load(dp_load), .dp_round(dp_round),
        .dp_final(dp_final), .round(round), .rkey_sel(rkey_sel), .key_loaded(key_loaded)
    );

    aes_round_ctrl #(.Nk(8)) u_dut8 (
        .clk(clk), .reset(reset), .key_valid(key_valid_b), .key_ready(key_ready_b),
        .exp_load(exp_load_b), .rkey(rk8), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .dp_load(dp_load_b),
        .dp_round(dp_round_b), .dp_final(dp_final_b), .round(round_b), .rkey_sel(rkey_sel_b),
        .key_loaded(key_loaded_b)
    );

    wire [11:0] ctl   = {key_ready, exp_load, in_ready, dp_load, dp_round, dp_final, out_valid,
                         key_loaded, round};
    wire [11:0] ctl_b = {key_ready_b, exp_load_b, in_ready_b, dp_load_b, dp_round_b, dp_final_b,
                         out_valid_b, key_loaded_b, round_b};

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    task automatic init_sbox();
        logic [7:0] inv, r, acc;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            r = inv;
            acc = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                acc = acc ^ r;
            end
            sbox_t[x] = acc ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Key schedule; word i at bits [32*i+:32], key words taken from the top of 'key'.
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] res;
        int            nw;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        res = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nw; i++) res[32*i+:32] = w[i];
        return res;
    endfunction

    // Round key r in rkey_sel packing (word 4r+j at bits [32*j+:32]).
    function automatic logic [127:0] rsel(input logic [1919:0] e, input int r);
        return {e[32*(4*r+3)+:32], e[32*(4*r+2)+:32], e[32*(4*r+1)+:32], e[32*(4*r)+:32]};
    endfunction

    // rkey_sel packing -> FIPS byte order (word 0 in the top bits).
    function automatic logic [127:0] fips(input logic [127:0] rs);
        return {rs[31:0], rs[63:32], rs[95:64], rs[127:96]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) t[4*c+r] = a[4*((c+r)%4)+r];
        end
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c];
                a1 = t[4*c+1];
                a2 = t[4*c+2];
                a3 = t[4*c+3];
                t[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                t[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
        return res;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [255:0] key, input int nk,
                                             input logic [127:0] p);
        logic [1919:0] e;
        logic [127:0]  s;
        e = expand(key, nk);
        s = p ^ fips(rsel(e, 0));
        for (int r = 1; r <= nk + 6; r++) s = aes_round(s, r == nk + 6) ^ fips(rsel(e, r));
        return s;
    endfunction

    function automatic logic [11:0] mk(input bit kr, input bit el, input bit ir, input bit dl,
                                       input bit dr, input bit df, input bit ov, input bit kl,
                                       input int rnd);
        return {kr, el, ir, dl, dr, df, ov, kl, 4'(rnd)};
    endfunction

    // ---------------- environment: key-expansion registers and round datapath ----------------
    always @(posedge clk) begin
        if (exp_load) begin
            ew4 = expand(kd, 4);
            for (int i = 0; i < 44; i++) rk4[i] <= ew4[32*i+:32];
        end
        if (dp_load) st4 <= pt ^ fips(rkey_sel);
        else if (dp_round) st4 <= aes_round(st4, dp_final) ^ fips(rkey_sel);
    end

    always @(posedge clk) begin
        if (exp_load_b) begin
            ew8 = expand(kd_b, 8);
            for (int i = 0; i < 60; i++) rk8[i] <= ew8[32*i+:32];
        end
        if (dp_load_b) st8 <= pt_b ^ fips(rkey_sel_b);
        else if (dp_round_b) st8 <= aes_round(st8, dp_final_b) ^ fips(rkey_sel_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    localparam logic [255:0] Key128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] Key256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] Pt   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] R0   = 128'h0c0d0e0f_08090a0b_04050607_00010203;
    localparam logic [127:0] R10  = 128'h4d2b30c5_f307a78b_e3944a17_13111d7f;
    localparam logic [127:0] Ct128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Ct256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        key_valid = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        settle();
        n_checks++;
        if (ctl !== mk(1, 1, 0, 0, 0, 0, 0, 0, 0))
            $display("FAIL reset_ctl: got %b expected %b", ctl, mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        else n_pass++;
        key_valid = 1'b0;
        #1;
        n_checks++;
        if (ctl !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0))
            $display("FAIL reset_exp_load: got %b expected %b", ctl,
                     mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        else n_pass++;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_no_key();
        in_valid = 1'b1;
        pt = Pt;
        for (int c = 0; c < 20; c++) begin
            settle();
            n_checks++;
            if (ctl !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0))
                $display("FAIL no_key c%0d: got %b expected %b", c, ctl,
                         mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
            else n_pass++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_key_load();
        kd = Key128;
        key_valid = 1'b1;
        settle();
        n_checks++;
        if (ctl !== mk(1, 1, 0, 0, 0, 0, 0, 0, 0))
            $display("FAIL key_accept: got %b expected %b", ctl, mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        else n_pass++;
        tick();
        key_valid = 1'b0;
        settle();
        n_checks++;
        if (ctl !== mk(1, 0, 1, 0, 0, 0, 0, 1, 0))
            $display("FAIL key_loaded: got %b expected %b", ctl, mk(1, 0, 1, 0, 0, 0, 0, 1, 0));
        else n_pass++;
        n_checks++;
        if (rkey_sel !== R0) $display("FAIL rkey_round0: got %h expected %h", rkey_sel, R0);
        else n_pass++;
        tick();
    endtask

    task automatic test_known_block();
        pt = Pt;
        in_valid = 1'b1;
        settle();
        n_checks++;
        if (ctl !== mk(1, 0, 1, 1, 0, 0, 0, 1, 0))
            $display("FAIL block_accept: got %b expected %b", ctl, mk(1, 0, 1, 1, 0, 0, 0, 1, 0));
        else n_pass++;
        tick();
        in_valid = 1'b0;
        // A key offered mid-block must be ignored.
        kd = {128'hffeeddccbbaa99887766554433221100, 128'h0};
        key_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            settle();
            n_checks++;
            if (ctl !== mk(0, 0, 0, 0, 1, c == 10, 0, 1, c))
                $display("FAIL run c%0d: got %b expected %b", c, ctl,
                         mk(0, 0, 0, 0, 1, c == 10, 0, 1, c));
            else n_pass++;
            if (c == 10) begin
                n_checks++;
                if (rkey_sel !== R10) $display("FAIL rkey_round10: got %h expected %h", rkey_sel, R10);
                else n_pass++;
            end
            tick();
        end
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            settle();
            n_checks++;
            if (ctl !== mk(0, 0, 0, 0, 0, 0, 1, 1, 10))
                $display("FAIL stall c%0d: got %b expected %b", c, ctl,
                         mk(0, 0, 0, 0, 0, 0, 1, 1, 10));
            else n_pass++;
            tick();
        end
        key_valid = 1'b0;
        kd = Key128;
        out_ready = 1'b1;
        settle();
        n_checks++;
        if (st4 !== Ct128) $display("FAIL ciphertext_128: got %h expected %h", st4, Ct128);
        else n_pass++;
        tick();
        settle();
        n_checks++;
        if (ctl !== mk(1, 0, 1, 0, 0, 0, 0, 1, 0))
            $display("FAIL back_idle: got %b expected %b", ctl, mk(1, 0, 1, 0, 0, 0, 0, 1, 0));
        else n_pass++;
        n_checks++;
        if (rkey_sel !== R0) $display("FAIL key_frozen: got %h expected %h", rkey_sel, R0);
        else n_pass++;
        tick();
    endtask

    task automatic test_simultaneous();
        logic [127:0] exp_ct;
        kd = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        pt = {$urandom, $urandom, $urandom, $urandom};
        key_valid = 1'b1;
        in_valid = 1'b1;
        settle();
        n_checks++;
        if (ctl !== mk(1, 1, 0, 0, 0, 0, 0, 1, 0))
            $display("FAIL simul_key_wins: got %b expected %b", ctl, mk(1, 1, 0, 0, 0, 0, 0, 1, 0));
        else n_pass++;
        tick();
        key_valid = 1'b0;
        settle();
        n_checks++;
        if (ctl !== mk(1, 0, 1, 1, 0, 0, 0, 1, 0))
            $display("FAIL simul_block_next: got %b expected %b", ctl,
                     mk(1, 0, 1, 1, 0, 0, 0, 1, 0));
        else n_pass++;
        exp_ct = aes_enc(kd, 4, pt);
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        settle();
        n_checks++;
        if (ctl !== mk(0, 0, 0, 0, 0, 0, 1, 1, 10))
            $display("FAIL simul_done: got %b expected %b", ctl, mk(0, 0, 0, 0, 0, 0, 1, 1, 10));
        else n_pass++;
        n_checks++;
        if (st4 !== exp_ct) $display("FAIL simul_ct: got %h expected %h", st4, exp_ct);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] exp_ct;
        pt = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        settle();
        n_checks++;
        if (ctl !== mk(0, 0, 0, 0, 1, 0, 0, 1, 5))
            $display("FAIL pre_reset_r5: got %b expected %b", ctl, mk(0, 0, 0, 0, 1, 0, 0, 1, 5));
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (ctl !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0))
            $display("FAIL reset_mid_run: got %b expected %b", ctl, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        else n_pass++;
        tick();
        reset = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            settle();
            n_checks++;
            if (ctl !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0))
                $display("FAIL reload_required c%0d: got %b expected %b", c, ctl,
                         mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
            else n_pass++;
            tick();
        end
        kd = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        settle();
        n_checks++;
        if (ctl !== mk(1, 0, 1, 1, 0, 0, 0, 1, 0))
            $display("FAIL reload_accept: got %b expected %b", ctl, mk(1, 0, 1, 1, 0, 0, 0, 1, 0));
        else n_pass++;
        exp_ct = aes_enc(kd, 4, pt);
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        settle();
        n_checks++;
        if (st4 !== exp_ct) $display("FAIL reload_ct: got %h expected %h", st4, exp_ct);
        else n_pass++;
        tick();
    endtask

    // Model: a block's life is counted in cycles since accept (1..Nr running, then done).
    task automatic test_random();
        bit           busy, kl;
        int           n;
        logic [255:0] mkey;
        logic [127:0] exp_ct;
        logic [11:0]  e;
        busy = 1'b0;
        kl = 1'b1;
        n = 0;
        mkey = kd;
        exp_ct = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            key_valid = ($urandom_range(0, 9) == 0);
            if (key_valid) kd = {$urandom, $urandom, $urandom, $urandom, 128'h0};
            in_valid = $urandom_range(0, 1);
            pt = {$urandom, $urandom, $urandom, $urandom};
            out_ready = $urandom_range(0, 1);
            settle();
            if (!busy) e = mk(1, key_valid, kl & ~key_valid, in_valid & kl & ~key_valid, 0, 0, 0, kl, 0);
            else if (n <= 10) e = mk(0, 0, 0, 0, 1, n == 10, 0, kl, n);
            else e = mk(0, 0, 0, 0, 0, 0, 1, kl, 10);
            n_checks++;
            if (ctl !== e) $display("FAIL rand_ctl cyc%0d: got %b expected %b", cyc, ctl, e);
            else n_pass++;
            if (busy && n > 10 && out_ready) begin
                n_checks++;
                if (st4 !== exp_ct) $display("FAIL rand_ct cyc%0d: got %h expected %h", cyc, st4, exp_ct);
                else n_pass++;
            end
            if (!busy) begin
                if (key_valid) begin
                    kl = 1'b1;
                    mkey = kd;
                end else if (in_valid && kl) begin
                    busy = 1'b1;
                    n = 1;
                    exp_ct = aes_enc(mkey, 4, pt);
                end
            end else if (n <= 10) begin
                n++;
            end else if (out_ready) begin
                busy = 1'b0;
            end
            tick();
        end
        key_valid = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_nk8();
        logic [1919:0] e;
        e = expand(Key256, 8);
        kd_b = Key256;
        key_valid_b = 1'b1;
        out_ready_b = 1'b1;
        settle();
        n_checks++;
        if (ctl_b !== mk(1, 1, 0, 0, 0, 0, 0, 0, 0))
            $display("FAIL nk8_key_accept: got %b expected %b", ctl_b, mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        else n_pass++;
        tick();
        key_valid_b = 1'b0;
        pt_b = Pt;
        in_valid_b = 1'b1;
        settle();
        n_checks++;
        if (ctl_b !== mk(1, 0, 1, 1, 0, 0, 0, 1, 0))
            $display("FAIL nk8_block_accept: got %b expected %b", ctl_b,
                     mk(1, 0, 1, 1, 0, 0, 0, 1, 0));
        else n_pass++;
        tick();
        in_valid_b = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            settle();
            n_checks++;
            if (ctl_b !== mk(0, 0, 0, 0, 1, c == 14, 0, 1, c))
                $display("FAIL nk8_run c%0d: got %b expected %b", c, ctl_b,
                         mk(0, 0, 0, 0, 1, c == 14, 0, 1, c));
            else n_pass++;
            n_checks++;
            if (rkey_sel_b !== rsel(e, c))
                $display("FAIL nk8_rkey c%0d: got %h expected %h", c, rkey_sel_b, rsel(e, c));
            else n_pass++;
            tick();
        end
        settle();
        n_checks++;
        if (ctl_b !== mk(0, 0, 0, 0, 0, 0, 1, 1, 14))
            $display("FAIL nk8_done: got %b expected %b", ctl_b, mk(0, 0, 0, 0, 0, 0, 1, 1, 14));
        else n_pass++;
        n_checks++;
        if (st8 !== Ct256) $display("FAIL ciphertext_256: got %h expected %h", st8, Ct256);
        else n_pass++;
        tick();
        settle();
        n_checks++;
        if (ctl_b !== mk(1, 0, 1, 0, 0, 0, 0, 1, 0))
            $display("FAIL nk8_back_idle: got %b expected %b", ctl_b, mk(1, 0, 1, 0, 0, 0, 0, 1, 0));
        else n_pass++;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        key_valid = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        kd = '0;
        pt = '0;
        key_valid_b = 1'b0;
        in_valid_b = 1'b0;
        out_ready_b = 1'b1;
        kd_b = '0;
        pt_b = '0;
        for (int i = 0; i < 44; i++) rk4[i] = '0;
        for (int i = 0; i < 60; i++) rk8[i] = '0;
        init_sbox();
        test_reset();
        test_no_key();
        test_key_load();
        test_known_block();
        test_simultaneous();
        test_reset_mid_run();
        test_random();
        test_nk8();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
